// File: rtl/pid_channel_sequencer.sv
// pid_channel_sequencer: one incremental PID datapath time-shared across NCH channels,
// with snapshot-on-tick inputs, shadowed runtime gains and per-channel saturated history.
module pid_channel_sequencer #(
   parameter int W = 15,
   parameter int NCH = 4,
   parameter int GW = 16,
   parameter int FRAC = 8,
   parameter logic signed [GW-1:0] K1_INIT = 16'sd77,
   parameter logic signed [GW-1:0] K2_INIT = -16'sd26,
   parameter logic signed [GW-1:0] K3_INIT = 16'sd0
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_tick,
   input  logic [NCH*(W+1)-1:0]    i_sp_bus,
   input  logic [NCH*(W+1)-1:0]    i_meas_bus,
   input  logic                    i_cfg_we,
   input  logic [1:0]              i_cfg_addr,
   input  logic [GW-1:0]           i_cfg_data,
   output logic                    o_busy,
   output logic                    o_u_valid,
   output logic [$clog2(NCH)-1:0]  o_u_ch,
   output logic [W:0]              o_u_out,
   output logic                    o_done,
   output logic                    o_overrun
);
   localparam int CW = $clog2(NCH);
   localparam int PW = W + GW + 3;
   localparam logic signed [W:0] UMAX = {1'b0, {W{1'b1}}};
   localparam logic signed [W:0] UMIN = {1'b1, {W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPD, S_DONE} state_t;
   state_t r_state, w_next;

   logic [NCH*(W+1)-1:0] r_sp, r_meas;
   logic signed [GW-1:0] r_k1, r_k2, r_k3, r_s1, r_s2, r_s3;
   logic signed [GW-1:0] w_n1, w_n2, w_n3;
   logic signed [W:0]    r_u [NCH];
   logic signed [W:0]    r_e1 [NCH];
   logic signed [W:0]    r_e2 [NCH];
   logic signed [W:0]    r_e, r_u_out;
   logic signed [PW-1:0] r_p, w_p, w_d;
   logic signed [PW:0]   w_sum;
   logic signed [W+1:0]  w_diff;
   logic signed [W:0]    w_sp, w_meas, w_e, w_u;
   logic [CW-1:0]        r_ch, r_u_ch;
   logic                 r_pend, r_valid, r_done, r_ovr;
   logic                 w_busy, w_start, w_last, w_clr, w_zero;

   function automatic logic signed [PW-1:0] mul(input logic signed [GW-1:0] k,
                                                input logic signed [W:0] x);
      return PW'(k) * PW'(x);
   endfunction

   // the done cycle is already IDLE but still counts as busy, so ticks there are refused
   assign w_busy  = (r_state != S_IDLE) | r_done;
   assign w_start = i_tick & ~w_busy;
   assign w_last  = r_ch == CW'(NCH - 1);
   assign w_clr   = i_cfg_we & (i_cfg_addr == 2'd3);
   assign w_zero  = (w_clr & ~w_busy) | (w_start & r_pend);
   assign w_n1 = (i_cfg_we && i_cfg_addr == 2'd0) ? i_cfg_data : r_s1;
   assign w_n2 = (i_cfg_we && i_cfg_addr == 2'd1) ? i_cfg_data : r_s2;
   assign w_n3 = (i_cfg_we && i_cfg_addr == 2'd2) ? i_cfg_data : r_s3;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_start ? S_CALC : S_IDLE;
         S_CALC:  w_next = S_UPD;
         S_UPD:   w_next = w_last ? S_DONE : S_CALC;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_sp   = r_sp[r_ch*(W+1) +: W+1];
      w_meas = r_meas[r_ch*(W+1) +: W+1];
      w_diff = (W+2)'(w_sp) - (W+2)'(w_meas);
      w_e    = (w_diff > (W+2)'(UMAX)) ? UMAX : (w_diff < (W+2)'(UMIN)) ? UMIN : w_diff[W:0];
      w_p    = mul(r_k1, w_e) + mul(r_k2, r_e1[r_ch]) + mul(r_k3, r_e2[r_ch]);
      w_d    = r_p >>> FRAC;
      w_sum  = (PW+1)'(r_u[r_ch]) + (PW+1)'(w_d);
      w_u    = (w_sum > (PW+1)'(UMAX)) ? UMAX : (w_sum < (PW+1)'(UMIN)) ? UMIN : w_sum[W:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_sp    <= '0;
         r_meas  <= '0;
         r_k1    <= K1_INIT;
         r_k2    <= K2_INIT;
         r_k3    <= K3_INIT;
         r_s1    <= K1_INIT;
         r_s2    <= K2_INIT;
         r_s3    <= K3_INIT;
         r_ch    <= '0;
         r_pend  <= 1'b0;
         r_p     <= '0;
         r_e     <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_ovr   <= 1'b0;
         r_u_out <= '0;
         r_u_ch  <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_u[i]  <= '0;
            r_e1[i] <= '0;
            r_e2[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_valid <= r_state == S_UPD;
         r_done  <= r_state == S_DONE;
         r_ovr   <= i_tick & w_busy;
         r_s1    <= w_n1;
         r_s2    <= w_n2;
         r_s3    <= w_n3;
         if (w_start) begin
            r_sp   <= i_sp_bus;
            r_meas <= i_meas_bus;
            r_k1   <= w_n1;
            r_k2   <= w_n2;
            r_k3   <= w_n3;
            r_ch   <= '0;
            r_pend <= 1'b0;
         end else if (w_clr & w_busy) begin
            r_pend <= 1'b1;
         end
         if (r_state == S_CALC) begin
            r_p <= w_p;
            r_e <= w_e;
         end
         // the clamped u is what gets stored, which is the anti-windup
         if (r_state == S_UPD) begin
            r_u[r_ch]  <= w_u;
            r_e1[r_ch] <= r_e;
            r_e2[r_ch] <= r_e1[r_ch];
            r_u_out    <= w_u;
            r_u_ch     <= r_ch;
            r_ch       <= r_ch + 1'b1;
         end
         if (w_zero) begin
            for (int i = 0; i < NCH; i++) begin
               r_u[i]  <= '0;
               r_e1[i] <= '0;
               r_e2[i] <= '0;
            end
         end
      end
   end

   assign o_busy    = w_busy;
   assign o_u_valid = r_valid;
   assign o_u_ch    = r_u_ch;
   assign o_u_out   = r_u_out;
   assign o_done    = r_done;
   assign o_overrun = r_ovr;
endmodule
